ds_dac_interp: RTL and testbench

- Upstream feeder for ds_dac.
- Accepts low-rate 16-bit unsigned samples over a valid/ready stream and buffers them in a small FIFO.
- Drives the DAC's din bus every clk50m cycle with a linear ramp from the previous sample to the new one over 2^LOG2_RATIO clocks.
- Removes zero-order-hold steps before the delta-sigma modulator and flags source underruns.

---
 rtl/ds_dac_pkg.sv | 16 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/ds_dac_interp.sv | 127 ++++++++++++
 tb/tb_ds_dac_interp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_dac_pkg.sv
// Shared types and default sizes for the delta-sigma DAC front end.
// The interpolator and its testbench both import this package.
package ds_dac_pkg;

   localparam int DEFAULT_DW         = 16;
   localparam int DEFAULT_LOG2_RATIO = 8;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } interp_state_t;

   typedef logic [DEFAULT_DW-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read data and registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk50m,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [AW:0]      w_count_next;
   logic             w_push;
   logic             w_pop;

   // Requests against a full or empty buffer are ignored rather than corrupting state.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
         full    <= (w_count_next == FULL_CNT);
         empty   <= (w_count_next == '0);
      end
   end

   // Storage has no reset so it can map onto distributed RAM.
   always_ff @(posedge clk50m) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   assign rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/ds_dac_interp.sv
// Linear interpolator feeding ds_dac: ramps din from the previous sample to each new
// sample over 2^LOG2_RATIO clocks, chaining ramps seamlessly and flagging underruns.
module ds_dac_interp
   import ds_dac_pkg::*;
#(
   parameter int DW         = DEFAULT_DW,
   parameter int LOG2_RATIO = DEFAULT_LOG2_RATIO,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic          clk50m,
   input  logic          rst,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [DW-1:0] din,
   output logic          busy,
   output logic          underrun
);

   localparam int AW = DW + LOG2_RATIO;
   localparam logic [LOG2_RATIO-1:0] CNT_LAST = '1;

   interp_state_t           r_state;
   interp_state_t           w_state_next;
   logic [AW-1:0]           r_acc;
   logic [AW-1:0]           w_acc_next;
   logic [AW-1:0]           w_sum;
   logic [AW-1:0]           w_delta_ext;
   logic signed [DW:0]      r_delta;
   logic signed [DW:0]      w_delta_next;
   logic [DW-1:0]           r_target;
   logic [DW-1:0]           w_target_next;
   logic [DW-1:0]           w_din_next;
   logic [LOG2_RATIO-1:0]   r_cnt;
   logic [LOG2_RATIO-1:0]   w_cnt_next;
   logic                    w_underrun_next;
   logic                    w_pop;
   logic                    w_push;
   logic [DW-1:0]           w_fifo_rdata;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;

   assign s_ready = !w_fifo_full;
   assign w_push  = s_valid && !w_fifo_full;

   sync_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk50m (clk50m),
      .rst    (rst),
      .push   (w_push),
      .pop    (w_pop),
      .wdata  (s_data),
      .rdata  (w_fifo_rdata),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty)
   );

   // Two's-complement step added to the fixed-point accumulator; after R steps the
   // accumulator lands exactly on {target, 0}, so the ramp never overshoots or wraps.
   assign w_delta_ext = AW'(r_delta);
   assign w_sum       = r_acc + w_delta_ext;

   always_comb begin
      w_state_next    = r_state;
      w_acc_next      = r_acc;
      w_delta_next    = r_delta;
      w_target_next   = r_target;
      w_cnt_next      = r_cnt;
      w_din_next      = din;
      w_underrun_next = 1'b0;
      w_pop           = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop         = 1'b1;
               w_target_next = w_fifo_rdata;
               w_delta_next  = $signed({1'b0, w_fifo_rdata}) - $signed({1'b0, din});
               w_acc_next    = {din, {LOG2_RATIO{1'b0}}};
               w_cnt_next    = '0;
               w_state_next  = RAMP;
            end
         end
         RAMP: begin
            w_acc_next = w_sum;
            w_cnt_next = r_cnt + 1'b1;
            w_din_next = w_sum[AW-1:LOG2_RATIO];
            if (r_cnt == CNT_LAST) begin
               // Final step: w_sum already equals {r_target, 0}, so chaining only needs a new delta.
               if (!w_fifo_empty) begin
                  w_pop         = 1'b1;
                  w_target_next = w_fifo_rdata;
                  w_delta_next  = $signed({1'b0, w_fifo_rdata}) - $signed({1'b0, r_target});
               end else begin
                  w_state_next    = IDLE;
                  w_underrun_next = 1'b1;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_delta  <= '0;
         r_target <= '0;
         r_cnt    <= '0;
         din      <= '0;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_acc    <= w_acc_next;
         r_delta  <= w_delta_next;
         r_target <= w_target_next;
         r_cnt    <= w_cnt_next;
         din      <= w_din_next;
         busy     <= (w_state_next == RAMP);
         underrun <= w_underrun_next;
      end
   end

endmodule

// File: tb/tb_ds_dac_interp.sv
// Scoreboard bench for ds_dac_interp: accepted samples are queued by the stimulus and a
// monitor checks every cycle against an ideal linear-ramp model computed from the endpoints.
module tb_ds_dac_interp;
   import ds_dac_pkg::*;

   localparam int DW    = 16;
   localparam int L2R   = 8;
   localparam int DEPTH = 4;
   localparam int R     = 1 << L2R;

   typedef struct {
      sample_t data;
      int      edge_no;
   } acc_t;

   logic    clk50m = 1'b0;
   logic    rst = 1'b1;
   sample_t s_data = '0;
   logic    s_valid = 1'b0;
   logic    s_ready;
   sample_t din;
   logic    busy;
   logic    underrun;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;
   int n_ramps = 0;

   // Model state, owned by the monitor.
   acc_t    exp_q[$];
   bit      m_ramping = 0;
   int      m_k = 0;
   sample_t m_prev = '0;
   sample_t m_tgt = '0;
   sample_t m_din = '0;
   bit      m_busy = 0;
   bit      m_und = 0;
   bit      m_ready = 1;
   sample_t last_sent = '0;

   ds_dac_interp #(
      .DW         (DW),
      .LOG2_RATIO (L2R),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk50m   (clk50m),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .din      (din),
      .busy     (busy),
      .underrun (underrun)
   );

   always #10 clk50m = ~clk50m;

   task automatic summary_and_finish();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   // Monitor: advances the ideal model one edge and compares all DUT outputs.
   initial begin : monitor
      bit      avail;
      bit      ended;
      longint  v;
      forever begin
         @(posedge clk50m);
         edge_n++;
         #1;
         if (rst) begin
            exp_q.delete();
            m_ramping = 0;
            m_k       = 0;
            m_prev    = '0;
            m_tgt     = '0;
            m_din     = '0;
            m_busy    = 0;
            m_und     = 0;
         end else begin
            m_und = 0;
            ended = 0;
            avail = (exp_q.size() > 0) && (exp_q[0].edge_no < edge_n);
            if (m_ramping) begin
               m_k++;
               v = longint'(m_prev) * R + longint'(m_k) * (longint'(m_tgt) - longint'(m_prev));
               m_din = sample_t'(v / R);
               if (m_k == R) begin
                  ended = 1;
                  m_ramping = 0;
                  n_ramps++;
                  $display("[TB] ramp %0d: %0d -> %0d, din=%0d", n_ramps, m_prev, m_tgt, din);
               end
            end
            if (!m_ramping && avail) begin
               m_prev    = m_din;
               m_tgt     = exp_q[0].data;
               m_k       = 0;
               m_ramping = 1;
               void'(exp_q.pop_front());
            end else if (ended) begin
               m_und = 1;
            end
            m_busy = m_ramping;
         end
         m_ready = (exp_q.size() < DEPTH);
         n_tests++;
         if (din !== m_din || busy !== m_busy || underrun !== m_und || s_ready !== m_ready) begin
            n_fail++;
            $display("FAIL cycle %0d: got din=%0d busy=%0b underrun=%0b s_ready=%0b, expected din=%0d busy=%0b underrun=%0b s_ready=%0b",
                     edge_n, din, busy, underrun, s_ready, m_din, m_busy, m_und, m_ready);
            if (n_fail >= 40) summary_and_finish();
         end
      end
   end

   // Offer one sample and hold it until accepted; s_valid stays high on return.
   task automatic send(input sample_t x);
      int waited = 0;
      @(negedge clk50m);
      s_valid = 1'b1;
      s_data  = x;
      while (s_ready !== 1'b1) begin
         @(negedge clk50m);
         waited++;
         if (waited > 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
            return;
         end
      end
      exp_q.push_back('{data: x, edge_no: edge_n + 1});
      last_sent = x;
   endtask

   task automatic idle_in(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk50m);
         s_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_ramping || exp_q.size() != 0) begin
         @(negedge clk50m);
         n++;
         if (n > 6000) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: model still busy after %0d cycles, required idle", n);
            return;
         end
      end
      idle_in(3);
   endtask

   initial begin : watchdog
      #5ms;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      summary_and_finish();
   end

   initial begin : stimulus
      sample_t x;
      int      n;
      // Reset with a valid sample presented: nothing may be captured.
      s_valid = 1'b1;
      s_data  = 16'd1234;
      repeat (3) @(negedge clk50m);
      rst     = 1'b0;
      s_valid = 1'b0;
      idle_in(4);

      // Single up ramp, then down ramp.
      send(16'd1000);
      idle_in(1);
      wait_idle();
      send(16'd0);
      idle_in(1);
      wait_idle();

      // Full scale back to back.
      send(16'd65535);
      send(16'd0);
      idle_in(1);
      wait_idle();

      // Continuous valid to exercise backpressure and ordering.
      for (int i = 0; i < 8; i++) send(sample_t'(1000 + 7000 * i));
      idle_in(1);
      wait_idle();

      // Reset 100 cycles into a 0 -> 40000 ramp with two samples queued.
      send(16'd0);
      idle_in(1);
      wait_idle();
      send(16'd40000);
      send(16'd111);
      send(16'd222);
      idle_in(1);
      n = 0;
      while (!(m_ramping && m_tgt == 16'd40000 && m_k >= 99) && n < 2000) begin
         @(negedge clk50m);
         n++;
      end
      rst = 1'b1;
      @(negedge clk50m);
      rst = 1'b0;
      last_sent = '0;
      idle_in(20);

      // Randomized traffic, with repeats (zero delta) and extremes mixed in.
      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 9))
            0:       x = last_sent;
            1:       x = 16'd0;
            2:       x = 16'hFFFF;
            default: x = sample_t'($urandom_range(0, 65535));
         endcase
         send(x);
         if ($urandom_range(0, 2) != 0) idle_in($urandom_range(1, 320));
      end
      idle_in(1);
      wait_idle();

      n_tests++;
      if (din !== last_sent) begin
         n_fail++;
         $display("FAIL final_din: got %0d, required %0d", din, last_sent);
      end
      summary_and_finish();
   end

endmodule
